// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle logic/arith/shift/compare ops plus
// iterative unsigned multiply, divide and remainder with registered status flags.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for an operation, in_ready = 1
//   CALC  | multi-cycle op iterating, one step per cycle
//   DONE  | result and flags held, out_valid = 1 until out_ready
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int OPW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    input  logic [OPW-1:0]   alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             negative,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    localparam logic [OPW-1:0] OP_ADD  = OPW'(1);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(2);
    localparam logic [OPW-1:0] OP_AND  = OPW'(3);
    localparam logic [OPW-1:0] OP_OR   = OPW'(4);
    localparam logic [OPW-1:0] OP_XOR  = OPW'(5);
    localparam logic [OPW-1:0] OP_NOR  = OPW'(6);
    localparam logic [OPW-1:0] OP_SLL  = OPW'(7);
    localparam logic [OPW-1:0] OP_SRL  = OPW'(8);
    localparam logic [OPW-1:0] OP_SRA  = OPW'(9);
    localparam logic [OPW-1:0] OP_SLT  = OPW'(10);
    localparam logic [OPW-1:0] OP_SLTU = OPW'(11);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(12);
    localparam logic [OPW-1:0] OP_DIVU = OPW'(13);
    localparam logic [OPW-1:0] OP_REMU = OPW'(14);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]    cnt;
    logic [OPW-1:0]   op_q;
    logic [WIDTH-1:0] reg_x;
    logic [WIDTH-1:0] reg_y;
    logic [WIDTH-1:0] reg_acc;

    logic             is_multi;
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   add_full;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] sc_result;
    logic             sc_carry;
    logic             sc_ovf;

    logic [WIDTH:0]   div_trial;
    logic             div_ge;
    logic [WIDTH-1:0] iter_x;
    logic [WIDTH-1:0] iter_y;
    logic [WIDTH-1:0] iter_acc;
    logic [WIDTH-1:0] md_result;

    assign is_multi = (alu_op == OP_MUL) || (alu_op == OP_DIVU) || (alu_op == OP_REMU);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // CALC exits on the edge where the counter steps from 1 to 0.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = is_multi ? CALC : DONE;
                end
            end
            CALC: begin
                if (cnt <= CW'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            CALC:    busy      = 1'b1;
            DONE:    out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    always_comb begin
        shamt     = alu_b[SHW-1:0];
        add_full  = {1'b0, alu_a} + {1'b0, alu_b};
        diff      = alu_a - alu_b;
        sc_result = '0;
        sc_carry  = 1'b0;
        sc_ovf    = 1'b0;
        case (alu_op)
            OP_ADD: begin
                sc_result = add_full[WIDTH-1:0];
                sc_carry  = add_full[WIDTH];
                sc_ovf    = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) &&
                            (add_full[WIDTH-1] != alu_a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_result = diff;
                sc_carry  = alu_a < alu_b;
                sc_ovf    = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) &&
                            (diff[WIDTH-1] != alu_a[WIDTH-1]);
            end
            OP_AND:  sc_result = alu_a & alu_b;
            OP_OR:   sc_result = alu_a | alu_b;
            OP_XOR:  sc_result = alu_a ^ alu_b;
            OP_NOR:  sc_result = ~(alu_a | alu_b);
            OP_SLL:  sc_result = alu_a << shamt;
            OP_SRL:  sc_result = alu_a >> shamt;
            OP_SRA:  sc_result = $signed(alu_a) >>> shamt;
            OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
            OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, (alu_a < alu_b)};
            default: sc_result = '0;
        endcase
    end

    // Shared iteration registers: mul uses x = multiplicand, y = multiplier,
    // acc = product; div uses x = dividend/quotient, y = divisor, acc = remainder.
    always_comb begin
        div_trial = {reg_acc, reg_x[WIDTH-1]};
        div_ge    = div_trial >= {1'b0, reg_y};
        iter_x    = reg_x;
        iter_y    = reg_y;
        iter_acc  = reg_acc;
        if (op_q == OP_MUL) begin
            iter_acc = reg_y[0] ? (reg_acc + reg_x) : reg_acc;
            iter_x   = reg_x << 1;
            iter_y   = reg_y >> 1;
        end else begin
            iter_x   = {reg_x[WIDTH-2:0], div_ge};
            iter_acc = div_ge ? (div_trial[WIDTH-1:0] - reg_y) : div_trial[WIDTH-1:0];
        end
        md_result = (op_q == OP_DIVU) ? iter_x : iter_acc;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_out  <= '0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            negative <= 1'b0;
            cnt      <= '0;
            op_q     <= '0;
            reg_x    <= '0;
            reg_y    <= '0;
            reg_acc  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q <= alu_op;
                        if (is_multi) begin
                            cnt     <= CW'(WIDTH);
                            reg_x   <= alu_a;
                            reg_y   <= alu_b;
                            reg_acc <= '0;
                        end else begin
                            alu_out  <= sc_result;
                            zero     <= (sc_result == '0);
                            negative <= sc_result[WIDTH-1];
                            carry    <= sc_carry;
                            overflow <= sc_ovf;
                        end
                    end
                end
                CALC: begin
                    reg_x   <= iter_x;
                    reg_y   <= iter_y;
                    reg_acc <= iter_acc;
                    cnt     <= (cnt == '0) ? '0 : cnt - CW'(1);
                    if (cnt <= CW'(1)) begin
                        alu_out  <= md_result;
                        zero     <= (md_result == '0);
                        negative <= md_result[WIDTH-1];
                        carry    <= 1'b0;
                        overflow <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Randomised scoreboard bench for alu_seq: driver pushes model expectations,
// a monitor pops and compares on every result handoff.
module tb_alu_seq;

    localparam int W = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;
    localparam longint UMAX = 64'sd4294967295;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [4:0]    alu_op;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  alu_out;
    logic          zero;
    logic          carry;
    logic          overflow;
    logic          negative;
    logic          busy;

    typedef struct {
        logic [W-1:0] res;
        logic         z;
        logic         c;
        logic         v;
        logic         n;
        int           lat;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   edge_cnt = 0;
    int   rmode = 0;

    alu_seq #(.WIDTH(W), .OPW(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_out   (alu_out),
        .zero      (zero),
        .carry     (carry),
        .overflow  (overflow),
        .negative  (negative),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        longint sa, sbv, ua, ub, t;
        logic [63:0] p;
        int sh;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        sh  = int'(b[4:0]);
        e.res = '0; e.c = 1'b0; e.v = 1'b0; e.lat = 1; e.acc = 0;
        case (op)
            5'd1: begin
                t = ua + ub; e.res = t[31:0]; e.c = t > UMAX;
                t = sa + sbv; e.v = (t > SMAX) || (t < SMIN);
            end
            5'd2: begin
                t = ua - ub; e.res = t[31:0]; e.c = ua < ub;
                t = sa - sbv; e.v = (t > SMAX) || (t < SMIN);
            end
            5'd3:  e.res = a & b;
            5'd4:  e.res = a | b;
            5'd5:  e.res = a ^ b;
            5'd6:  e.res = ~(a | b);
            5'd7:  e.res = a << sh;
            5'd8:  e.res = a >> sh;
            5'd9:  begin t = sa >>> sh; e.res = t[31:0]; end
            5'd10: e.res = (sa < sbv) ? 32'd1 : 32'd0;
            5'd11: e.res = (ua < ub) ? 32'd1 : 32'd0;
            5'd12: begin p = {32'd0, a} * {32'd0, b}; e.res = p[31:0]; e.lat = W + 1; end
            5'd13: begin e.res = (b == 0) ? 32'hFFFF_FFFF : a / b; e.lat = W + 1; end
            5'd14: begin e.res = (b == 0) ? a : a % b; e.lat = W + 1; end
            default: e.res = '0;
        endcase
        e.z = (e.res == 0);
        e.n = e.res[31];
        return e;
    endfunction

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("in_ready timeout", {31'd0, in_ready}, 32'd1);
            return;
        end
        alu_op = op; alu_a = a; alu_b = b; in_valid = 1'b1;
        @(posedge clk);
        #1;
        e = model(op, a, b);
        e.acc = edge_cnt;
        sb.push_back(e);
        in_valid = 1'b0;
        alu_op = 5'($urandom); alu_a = $urandom; alu_b = $urandom;
    endtask

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (rmode == 0) out_ready = ($urandom_range(0, 3) != 0);
            else            out_ready = 1'b0;
        end
    end

    // Monitor: latency on the rising edge of out_valid, contents at handoff.
    initial begin
        logic prev_v;
        exp_t e;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid && !prev_v) begin
                if (sb.size() == 0) check("unexpected out_valid", 32'd1, 32'd0);
                else check("latency", 32'(edge_cnt - sb[0].acc + 1), 32'(sb[0].lat));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected handoff", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("result",   alu_out, e.res);
                    check("zero",     {31'd0, zero},     {31'd0, e.z});
                    check("carry",    {31'd0, carry},    {31'd0, e.c});
                    check("overflow", {31'd0, overflow}, {31'd0, e.v});
                    check("negative", {31'd0, negative}, {31'd0, e.n});
                end
            end
            prev_v = out_valid;
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        exp_t e;
        int n, nb;
        logic seen;
        logic [4:0] op;
        logic [W-1:0] a, b;

        rst_n = 1'b0;
        in_valid = 1'($urandom); alu_op = 5'($urandom); alu_a = $urandom; alu_b = $urandom;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst alu_out",   alu_out, 32'd0);
        check("rst flags",     {28'd0, zero, carry, overflow, negative}, 32'd0);
        check("rst busy",      {31'd0, busy}, 32'd0);
        check("rst in_ready",  {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("post-rst in_ready", {31'd0, in_ready}, 32'd1);

        issue(5'd1,  32'h7FFF_FFFF, 32'd1);
        issue(5'd2,  32'd3, 32'd5);
        issue(5'd9,  32'h8000_0000, 32'h21);
        issue(5'd10, 32'hFFFF_FFFF, 32'd1);
        issue(5'd11, 32'hFFFF_FFFF, 32'd1);
        issue(5'd13, 32'd100, 32'd7);
        issue(5'd14, 32'd100, 32'd7);
        issue(5'd13, 32'd5, 32'd0);
        issue(5'd14, 32'd5, 32'd0);
        issue(5'd20, 32'h1234, 32'h5678);

        // Busy and in_ready through a full multiply.
        issue(5'd12, 32'h0001_0000, 32'h0001_0001);
        n = 0; nb = 0;
        do begin
            @(negedge clk);
            if (!out_valid && busy && !in_ready) nb++;
            n++;
        end while (!out_valid && n < 100);
        check("mul busy cycles", 32'(nb), 32'(W));

        for (int i = 0; i < 80; i++) begin
            op = 5'($urandom_range(0, 31));
            a  = rnd_val();
            b  = rnd_val();
            if ((op == 5'd13 || op == 5'd14) && $urandom_range(0, 1) == 1)
                b = 32'($urandom_range(0, 20));
            issue(op, a, b);
        end
        drain();

        // Backpressure: result must hold while inputs churn.
        rmode = 1;
        @(posedge clk);
        #3;
        a = $urandom; b = $urandom;
        e = model(5'd5, a, b);
        issue(5'd5, a, b);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 50);
        check("bp valid", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; alu_op = 5'($urandom); alu_a = $urandom; alu_b = $urandom;
            @(negedge clk);
            check("bp hold",     alu_out, e.res);
            check("bp in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        rmode = 0;
        drain();

        // Reset during a multiply abandons it.
        issue(5'd12, $urandom, $urandom);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        sb.delete(sb.size() - 1);
        @(negedge clk);
        check("abort busy",      {31'd0, busy}, 32'd0);
        check("abort in_ready",  {31'd0, in_ready}, 32'd1);
        check("abort out_valid", {31'd0, out_valid}, 32'd0);
        check("abort alu_out",   alu_out, 32'd0);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("abort no pulse", {31'd0, seen}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
